// File: rtl/trap_pkg.sv
// trap_pkg: shared FSM states, interrupt cause codes and trap CSR addresses
package trap_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
   typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;
   localparam logic [3:0] IRQ_MEI = 4'd11;
   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [11:0] CSR_MTVEC = 12'h305;
   localparam logic [11:0] CSR_MEPC = 12'h341;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: picks the highest-priority enabled pending M-mode interrupt
module irq_prio_enc
   import trap_pkg::*;
(
   input  logic       mie,
   input  logic [2:0] mxie,
   input  logic [2:0] mxip,
   output logic       valid,
   output logic [3:0] code
);
   logic [2:0] pend;
   always_comb begin
      pend = mxip & mxie & {3{mie}};
      valid = |pend;
      code = pend[0] ? IRQ_MEI : pend[1] ? IRQ_MSI : IRQ_MTI;
   end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions/interrupts/mret, drains the pipe,
// commits the trap to the CSR file and issues a single fetch redirect
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int CAUSE_W = 4,
   parameter int XLEN = 32
) (
   input  logic               ctrl_clk,
   input  logic               ctrl_reset,
   input  logic               exc_req,
   input  logic [CAUSE_W-1:0] exc_code,
   input  logic [XLEN-1:0]    exc_pc,
   input  logic               mret_req,
   input  logic [XLEN-1:0]    next_pc,
   input  logic               ctrl_mie,
   input  logic [2:0]         ctrl_mxie,
   input  logic [2:0]         ctrl_mxip,
   output logic               pipe_flush,
   input  logic               pipe_idle,
   output logic [11:0]        csr_raddr,
   input  logic [XLEN-1:0]    csr_rdata,
   output logic               ctrl_trap,
   output logic               ctrl_mret,
   output logic [XLEN-1:0]    trap_pc,
   output logic [CAUSE_W:0]   trap_info,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               busy
);
   state_t state, state_nxt, st;
   kind_t kind_q;
   logic [CAUSE_W:0] info_q;
   logic [XLEN-1:0] pc_q, target_q, target_nxt, base;
   logic irq_valid;
   logic [3:0] irq_code;

   irq_prio_enc u_enc (
      .mie  (ctrl_mie),
      .mxie (ctrl_mxie),
      .mxip (ctrl_mxip),
      .valid(irq_valid),
      .code (irq_code)
   );

   always_ff @(posedge ctrl_clk) begin
      if (ctrl_reset) begin
         state <= IDLE;
         kind_q <= K_EXC;
         info_q <= '0;
         pc_q <= '0;
         target_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (exc_req) begin
               kind_q <= K_EXC;
               info_q <= {1'b0, exc_code};
               pc_q <= exc_pc;
            end else if (mret_req) begin
               kind_q <= K_MRET;
               info_q <= '0;
               pc_q <= '0;
            end else if (irq_valid) begin
               kind_q <= K_IRQ;
               info_q <= {1'b1, CAUSE_W'(irq_code)};
            end
         end
         // interrupt mepc is the oldest uncommitted pc once the pipe is empty
         if (state == DRAIN && pipe_idle && kind_q == K_IRQ) pc_q <= next_pc;
         if (state == COMMIT) target_q <= target_nxt;
      end
   end

   always_comb begin
      st = ctrl_reset ? IDLE : state;
      state_nxt = state == IDLE   ? ((exc_req || mret_req || irq_valid) ? DRAIN : IDLE) :
                  state == DRAIN  ? (pipe_idle ? COMMIT : DRAIN) :
                  state == COMMIT ? REDIRECT : IDLE;
      base = {csr_rdata[XLEN-1:2], 2'b00};
      target_nxt = kind_q == K_MRET ? csr_rdata :
                   (kind_q == K_IRQ && csr_rdata[1:0] == 2'b01) ?
                   base + (XLEN'(info_q[CAUSE_W-1:0]) << 2) : base;
      busy = st != IDLE;
      pipe_flush = busy;
      csr_raddr = !busy ? 12'h000 : kind_q == K_MRET ? CSR_MEPC : CSR_MTVEC;
      ctrl_trap = st == COMMIT;
      ctrl_mret = ctrl_trap && kind_q == K_MRET;
      trap_pc = ctrl_trap ? pc_q : '0;
      trap_info = ctrl_trap ? info_q : '0;
      redirect_valid = st == REDIRECT;
      redirect_pc = redirect_valid ? target_q : '0;
   end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and random events against a rule-level model
module tb_trap_sequencer;
   logic ctrl_clk = 0, ctrl_reset = 1;
   logic exc_req = 0, mret_req = 0, ctrl_mie = 0, pipe_idle = 0;
   logic [3:0] exc_code = 0;
   logic [31:0] exc_pc = 0, next_pc = 0, mtvec = 0, mepc = 0;
   logic [2:0] ctrl_mxie = 0, ctrl_mxip = 0;
   logic pipe_flush, ctrl_trap, ctrl_mret, redirect_valid, busy;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata, trap_pc, redirect_pc;
   logic [4:0] trap_info;
   int total = 0, bad = 0;

   typedef struct packed {
      logic take;
      logic mret;
      logic [4:0] info;
      logic [31:0] pc;
      logic [31:0] target;
      logic [11:0] raddr;
   } exp_t;

   trap_sequencer #(.CAUSE_W(4), .XLEN(32)) dut (
      .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset), .exc_req(exc_req),
      .exc_code(exc_code), .exc_pc(exc_pc), .mret_req(mret_req),
      .next_pc(next_pc), .ctrl_mie(ctrl_mie), .ctrl_mxie(ctrl_mxie),
      .ctrl_mxip(ctrl_mxip), .pipe_flush(pipe_flush), .pipe_idle(pipe_idle),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .ctrl_trap(ctrl_trap),
      .ctrl_mret(ctrl_mret), .trap_pc(trap_pc), .trap_info(trap_info),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 ctrl_clk = ~ctrl_clk;

   // behavioural CSR file read port
   assign csr_rdata = csr_raddr == 12'h305 ? mtvec : csr_raddr == 12'h341 ? mepc : 32'hDEADBEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ctrl_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge ctrl_clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " flush"}, 32'(pipe_flush), 0);
      check({tag, " strobes"}, 32'({ctrl_trap, ctrl_mret, redirect_valid}), 0);
      check({tag, " raddr"}, 32'(csr_raddr), 0);
      check({tag, " data"}, trap_pc | 32'(trap_info) | redirect_pc, 0);
   endtask

   function automatic exp_t model(input bit exc, input logic [3:0] code, input logic [31:0] epc,
                                  input bit mret, input bit mie, input logic [2:0] xie,
                                  input logic [2:0] xip, input logic [31:0] npc,
                                  input logic [31:0] tvec, input logic [31:0] mepc_v);
      exp_t e;
      int irq_codes[3] = '{11, 3, 7};
      e = '0;
      if (exc) begin
         e.take = 1; e.info = {1'b0, code}; e.pc = epc;
         e.target = tvec & ~32'h3; e.raddr = 12'h305;
      end else if (mret) begin
         e.take = 1; e.mret = 1; e.target = mepc_v; e.raddr = 12'h341;
      end else if (mie) begin
         for (int i = 0; i < 3; i++) begin
            if (!e.take && xie[i] && xip[i]) begin
               e.take = 1; e.info = {1'b1, 4'(irq_codes[i])}; e.pc = npc; e.raddr = 12'h305;
               e.target = (tvec & ~32'h3) + ((tvec[1:0] == 2'b01) ? 32'(4 * irq_codes[i]) : 0);
            end
         end
      end
      return e;
   endfunction

   task automatic run_event(input bit exc, input logic [3:0] code, input logic [31:0] epc,
                            input bit mret, input bit mie, input logic [2:0] xie,
                            input logic [2:0] xip, input logic [31:0] npc,
                            input logic [31:0] tvec, input logic [31:0] mepc_v, input int dly);
      exp_t e;
      e = model(exc, code, epc, mret, mie, xie, xip, npc, tvec, mepc_v);
      mtvec = tvec; mepc = mepc_v;
      exc_req = exc; exc_code = code; exc_pc = epc; mret_req = mret;
      ctrl_mie = mie; ctrl_mxie = xie; ctrl_mxip = xip; pipe_idle = 0;
      smp();
      check("accept busy", 32'(busy), 0);
      tick();
      exc_req = 0; mret_req = 0;
      if (!e.take) begin
         for (int k = 0; k < 4; k++) begin
            smp();
            check("no-event quiet", 32'({busy, ctrl_trap, redirect_valid}), 0);
            tick();
         end
         ctrl_mie = 0; ctrl_mxip = 0;
         return;
      end
      // noise during drain must not disturb the latched event
      for (int k = 0; k < dly; k++) begin
         next_pc = $urandom; ctrl_mxip = 3'($urandom); exc_code = 4'($urandom);
         exc_req = 1'($urandom); mret_req = 1'($urandom);
         smp();
         check("drain flush", 32'(pipe_flush), 1);
         check("drain trap", 32'(ctrl_trap), 0);
         check("drain raddr", 32'(csr_raddr), 32'(e.raddr));
         tick();
      end
      pipe_idle = 1; next_pc = npc; exc_req = 0; mret_req = 0; ctrl_mxip = 0; ctrl_mie = 0;
      smp();
      check("drain-end flush", 32'(pipe_flush), 1);
      check("drain-end trap", 32'(ctrl_trap), 0);
      check("drain-end raddr", 32'(csr_raddr), 32'(e.raddr));
      tick();
      pipe_idle = 0;
      smp();
      check("commit trap", 32'(ctrl_trap), 1);
      check("commit mret", 32'(ctrl_mret), 32'(e.mret));
      check("commit trap_pc", trap_pc, e.pc);
      check("commit trap_info", 32'(trap_info), 32'(e.info));
      check("commit flush", 32'(pipe_flush), 1);
      check("commit redirect", 32'(redirect_valid), 0);
      tick();
      smp();
      check("redirect valid", 32'(redirect_valid), 1);
      check("redirect pc", redirect_pc, e.target);
      check("redirect trap", 32'({ctrl_trap, ctrl_mret}), 0);
      check("redirect flush", 32'(pipe_flush), 1);
      tick();
      smp();
      check_quiet("back idle");
      tick();
   endtask

   initial begin
      repeat (2) tick();
      smp();
      check_quiet("reset");
      tick();
      ctrl_reset = 0;
      tick();
      run_event(1, 4'd11, 32'h100, 0, 0, 3'b000, 3'b000, 32'h0, 32'h80000000, 32'h0, 0);
      run_event(0, 4'd0, 32'h0, 0, 1, 3'b100, 3'b100, 32'h200, 32'h80000001, 32'h0, 0);
      run_event(0, 4'd0, 32'h0, 0, 1, 3'b111, 3'b111, 32'h240, 32'h80000001, 32'h0, 1);
      run_event(0, 4'd0, 32'h0, 0, 1, 3'b110, 3'b111, 32'h280, 32'h80000001, 32'h0, 0);
      run_event(0, 4'd0, 32'h0, 0, 0, 3'b111, 3'b111, 32'h240, 32'h80000001, 32'h0, 0);
      run_event(0, 4'd0, 32'h0, 1, 0, 3'b000, 3'b000, 32'h0, 32'h80000000, 32'h344, 0);
      run_event(1, 4'd2, 32'h400, 1, 1, 3'b111, 3'b111, 32'h0, 32'h80000000, 32'h344, 0);
      run_event(1, 4'd5, 32'h500, 0, 0, 3'b000, 3'b000, 32'h0, 32'h12345677, 32'h0, 5);
      // reset while draining abandons the event
      exc_req = 1; exc_code = 4'd4; exc_pc = 32'h600;
      tick();
      exc_req = 0; pipe_idle = 1; ctrl_reset = 1;
      tick();
      ctrl_reset = 0;
      smp();
      check_quiet("post-reset");
      tick();
      for (int k = 0; k < 5; k++) begin
         smp();
         check("post-reset quiet", 32'({busy, ctrl_trap, redirect_valid}), 0);
         tick();
      end
      pipe_idle = 0;
      for (int n = 0; n < 150; n++)
         run_event($urandom_range(0, 3) == 0, 4'($urandom), $urandom, $urandom_range(0, 3) == 0,
                   1'($urandom), 3'($urandom), 3'($urandom), $urandom,
                   {$urandom_range(0, 32'h3FFFFFFF), 2'($urandom)}, $urandom,
                   $urandom_range(0, 4));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Central trap/interrupt/mret controller for the M-mode core. Sits between the pipeline and the CSR file.
- Selects the highest-priority pending event and drains the pipeline. Then pulses ctrl_trap / ctrl_mret with trap_pc / trap_info into the CSR file, reads mtvec or mepc through a CSR read port, and issues one fetch redirect.
- Only agent allowed to drive the CSR file's trap-side inputs.

Parameters:
- CAUSE_W, 4, width of exception/interrupt code (trap_info = {is_irq, code}).
- XLEN, 32, address/data width.

Ports:
- ctrl_clk  in  1  clock
- ctrl_reset  in  1  synchronous active-high reset
- exc_req  in  1  synchronous exception from the commit stage
- exc_code  in  CAUSE_W  exception cause
- exc_pc  in  XLEN  pc of the faulting instruction
- mret_req  in  1  mret reached the commit stage
- next_pc  in  XLEN  pc of the oldest uncommitted instruction
- ctrl_mie  in  1  mstatus.MIE from the CSR file
- ctrl_mxie  in  3  enables: [0] external, [1] software, [2] timer
- ctrl_mxip  in  3  pending, same bit order
- pipe_flush  out  1  kill younger instructions and stop fetch
- pipe_idle  in  1  pipeline empty and no CSR write in flight
- csr_raddr  out  12  CSR read address (drives the CSR file's second read port)
- csr_rdata  in  32  CSR read data
- ctrl_trap  out  1  one-cycle trap/mret commit strobe to the CSR file
- ctrl_mret  out  1  qualifies ctrl_trap as mret
- trap_pc  out  XLEN  mepc value for a trap
- trap_info  out  5  {interrupt, code[3:0]}
- redirect_valid  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
- Reset value of every output is 0. State resets to IDLE and all latches clear. Reset in any state returns to IDLE the next cycle, with no strobe issued.
- IDLE event priority:
  - exc_req wins over mret_req.
  - mret_req wins over an interrupt.
  - Interrupt only if ctrl_mie=1 and (ctrl_mxip & ctrl_mxie) != 0.
  - Among interrupts: external (code 11) > software (3) > timer (7).
- On an accepted event, latch kind (EXC/IRQ/MRET), trap_info and pc, then go to DRAIN.
  - EXC: pc = exc_pc, trap_info = {0, exc_code}.
  - IRQ: trap_info = {1, code}.
- DRAIN:
  - pipe_flush = 1. Inputs exc_req, mret_req and irq are ignored.
  - The latched interrupt is taken even if its pending bit drops.
  - csr_raddr = 0x305 (mtvec) for EXC/IRQ, 0x341 (mepc) for MRET.
  - When pipe_idle = 1: IRQ latches pc = next_pc that cycle, then go to COMMIT. No timeout.
- COMMIT:
  - ctrl_trap = 1 for exactly one cycle; ctrl_mret = 1 iff MRET. trap_pc and trap_info are driven from the latches.
  - csr_rdata is registered as the target, using the pre-trap value (mtvec/mepc are unaffected by the commit).
  - Target computation:
    - MRET: target = csr_rdata.
    - EXC: target = {csr_rdata[31:2], 2'b00}.
    - IRQ with mode (csr_rdata[1:0]) == 1: target = {base, 2'b00} + 4*code, modulo 2^32.
    - IRQ with mode 0: target = base.
  - pipe_flush stays 1.
- REDIRECT: redirect_valid = 1 for one cycle, redirect_pc = target. pipe_flush drops in the next cycle. Return to IDLE.
- Minimum latency: event at cycle 0 with pipe_idle already 1 in cycle 1 gives ctrl_trap in cycle 2, redirect in cycle 3 and IDLE in cycle 4. The next event can be accepted in cycle 4.
- trap_pc, trap_info and ctrl_mret are 0 outside COMMIT. csr_raddr is 0 in IDLE.

Decomposition:
- Shared package trap_pkg holds:
  - state enum;
  - interrupt code constants IRQ_MEI=11, IRQ_MSI=3, IRQ_MTI=7;
  - CSR address constants CSR_MTVEC, CSR_MEPC, which the CSR file also imports.
- One sub-module: irq_prio_enc (combinational). Inputs: mie, mxie, mxip. Outputs: valid, code[3:0].

Test Plan:
- exc_req=1, exc_code=11, exc_pc=0x100, pipe_idle=1, mtvec=0x80000000 -> ctrl_trap one cycle with trap_info=0x0B, trap_pc=0x100, ctrl_mret=0; redirect_pc=0x80000000 one cycle later.
- mtvec=0x80000001, ctrl_mie=1, mxie=mxip=3'b100, next_pc=0x200 -> trap_info=0x17, trap_pc=0x200, redirect_pc=0x8000001C.
- mxie=mxip=3'b111, ctrl_mie=1, mtvec=0x80000001 -> trap_info=0x1B, redirect_pc=0x8000002C. Same with ctrl_mie=0 -> busy stays 0, no strobes.
- mret_req=1, mepc=0x344 -> ctrl_trap=ctrl_mret=1 one cycle, redirect_pc=0x344. exc_req and mret_req in the same cycle -> exception path, ctrl_mret=0.
- pipe_idle held low 5 cycles after exc_req -> pipe_flush high throughout, ctrl_trap exactly 1 cycle after pipe_idle rises, new exc_req during DRAIN ignored.
- ctrl_reset pulsed during DRAIN -> IDLE next cycle, all outputs 0, no ctrl_trap and no redirect ever issued for that event.
